// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: access size codes, FSM states,
// and the wait-state counter width.
package dmem_responder_pkg;

    localparam int WS_W = 4;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU load/store bus between the multi-cycle CPU (master) and the data-memory
// responder (slave).
interface dmem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, size, wdata,
        input  busy, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, size, wdata,
        output busy, ack, rdata, err
    );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering shared by the store and load paths: byte enables plus a
// replicated write word, and right-justified zero-filled read extraction.
module dmem_responder_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [4:0] w_bit_ofs;

    assign w_bit_ofs = {i_addr_lo, 3'b000};

    // Write data is replicated into every lane; o_be picks the lanes that land.
    always_comb begin
        o_be    = 4'b0000;
        o_wword = 32'h0;
        o_rdata = 32'h0;
        case (i_size)
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
            SZ_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
                o_rdata = {16'h0, (i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0])};
            end
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = {24'h0, i_rword[w_bit_ofs +: 8]};
            end
            default: begin
                o_be    = 4'b0000;
                o_wword = 32'h0;
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding access, programmable wait states,
// one-cycle ack qualified by err.
//
//   state   | meaning
//   IDLE    | ready; req latches the access
//   WAIT    | counting down the wait states
//   RESP    | ack cycle; store commits at the end of it, load data on rdata
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WS_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

    state_e            r_state;
    state_e            w_next;
    logic [WS_W-1:0]   r_cnt;
    logic [WS_W-1:0]   w_cnt_next;
    logic              w_accept;

    logic              r_we;
    logic [31:0]       r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_rword;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;
    logic [31:0]       w_rdata_al;
    logic              w_oor;
    logic              w_err;
    logic              w_resp;
    logic              w_mem_we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_size  <= SZ_WORD;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_size  <= bus.size;
                r_wdata <= bus.wdata;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_accept   = 1'b1;
                    w_cnt_next = CNT_LOAD;
                    w_next     = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Out-of-range addresses are rejected rather than folded onto the array.
    assign w_oor = (r_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err = (r_size == SZ_ILL)
                 || ((r_size == SZ_HALF) && r_addr[0])
                 || ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00))
                 || w_oor;

    assign w_idx   = r_addr[IDX_W+1:2];
    assign w_rword = r_mem[w_idx];

    dmem_responder_lane_align u_align (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wword   (w_wword),
        .o_rdata   (w_rdata_al)
    );

    assign w_resp   = (r_state == ST_RESP);
    // A reset landing on the RESP edge must drop the pending store.
    assign w_mem_we = reset && w_resp && r_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.ack   = w_resp;
    assign bus.err   = w_resp && w_err;
    assign bus.rdata = (w_resp && !r_we && !w_err) ? w_rdata_al : 32'h0;

endmodule
